foc_inv_park: RTL and testbench
===============================

FOC_INV_PARK -- requirements
Module: foc_inv_park

Interface
- REQ-001 Parameter SIN_LAT, default 2: fixed latency in cycles from angle_o to valid sin_i (range 1..7).
- REQ-002 Parameter ANG_W, default 12: angle width; one electrical turn equals 2^ANG_W counts.
- REQ-003 clk  input  1  single clock; all logic on its rising edge.
- REQ-004 rst  input  1  reset, synchronous, active-high.
- REQ-005 start_i  input  1  request pulse; vd_i, vq_i and angle_i are valid in the same cycle.
- REQ-006 vd_i  input  32  signed D-axis voltage command.
- REQ-007 vq_i  input  32  signed Q-axis voltage command.
- REQ-008 angle_i  input  ANG_W  unsigned electrical angle.
- REQ-009 angle_o  output  ANG_W  address to the shared sine table.
- REQ-010 sin_i  input  16  signed Q1.15 sine-table return, valid SIN_LAT cycles after angle_o.
- REQ-011 valpha_o  output  32  signed alpha-axis voltage.
- REQ-012 vbeta_o  output  32  signed beta-axis voltage.
- REQ-013 busy_o  output  1  high from the cycle after start acceptance through the DONE cycle.
- REQ-014 done_o  output  1  one-cycle pulse; valpha_o and vbeta_o are updated in the same cycle.

Function
- REQ-015 FSM states: IDLE, SIN, COS, MAC, DONE; DONE always returns to IDLE after one cycle.
- REQ-016 start_i is accepted only in IDLE; vd_i, vq_i and angle_i are latched in the acceptance cycle T; start_i outside IDLE is ignored, with no queueing.
- REQ-017 SIN: lasts SIN_LAT+1 cycles; angle_o = latched angle; sin_i is captured as S on the last cycle.
- REQ-018 COS: lasts SIN_LAT+1 cycles; angle_o = (angle + 2^(ANG_W-2)) mod 2^ANG_W; sin_i is captured as C on the last cycle.
- REQ-019 MAC: lasts 4 cycles, one product per cycle in the order vd*C, vq*S, vd*S, vq*C, using a single multiplier.
- REQ-020 Product rule: 32x16 signed gives 48 bits; arithmetic shift right 15, floor toward minus infinity; each product is accumulated in a 34-bit signed accumulator.
- REQ-021 valpha = P(vd,C) - P(vq,S); vbeta = P(vd,S) + P(vq,C); each 34-bit result is reduced to 32 bits per REQ-029/030.
- REQ-022 Latency: done_o is high in cycle T+2*SIN_LAT+7 (T+11 at default); busy_o is low in IDLE only.
- REQ-023 In IDLE, angle_o holds its last driven value; valpha_o and vbeta_o hold their values between done pulses.
- REQ-024 sin_i = -32768 and vd/vq = -2^31 are legal and need no special case.
- REQ-025 start_i in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.

Reset
- REQ-026 rst high at a clock edge forces: state IDLE, valpha_o = 0, vbeta_o = 0, angle_o = 0, busy_o = 0, done_o = 0, accumulators = 0.
- REQ-027 rst during any non-IDLE state aborts the operation without a done_o pulse.
- REQ-028 rst has priority over start_i in the same cycle.

Configuration
- REQ-029 With INV_PARK_SAT_EN defined, each 34-bit result saturates to [-2^31, 2^31-1].
- REQ-030 Without INV_PARK_SAT_EN, each result keeps its low 32 bits (two's-complement wrap); no saturation logic is present.

Structure
- REQ-031 Package foc_pkg holds: ANG_W default, QUARTER_TURN = 1024, the Q15 shift constant (15), and the FSM state enum.
- REQ-032 One sub-module, foc_mul_q15, holds the combinational signed 32x16 multiply with >>>15; it is instantiated once.

Verification
- REQ-033 Table model sin(0)=0, cos=32767; vd=0, vq=1000, angle=0 -> angle_o 0 then 1024, valpha=0, vbeta=999, done at T+11.
- REQ-034 vd=0, vq=1000, angle=1024 (S=32767, C=0) -> valpha=-999, vbeta=0.
- REQ-035 angle=3500 -> angle_o=3500 for 3 cycles, then 428 for 3 cycles (quarter-turn wrap).
- REQ-036 vd=2^31-1, vq=-(2^31-1), S=C=23170 -> with INV_PARK_SAT_EN: valpha=0x7FFFFFFF; without it: the low 32 bits of the exact sum.
- REQ-037 start during MAC is ignored -> only one done pulse; rst asserted in MAC -> next cycle busy_o=0, outputs 0, no done.
- REQ-038 Back-to-back starts: a second start in the cycle after done -> accepted, done exactly 2*SIN_LAT+7 cycles later; repeat with SIN_LAT=1 and SIN_LAT=7.

Source files
------------

// File: rtl/foc_pkg.sv
// foc_pkg: constants and FSM state encoding shared by the inverse Park transform.
package foc_pkg;

  localparam int ANG_W_DEF    = 12;
  localparam int QUARTER_TURN = 1024;
  localparam int Q15_SHIFT    = 15;

  typedef enum logic [2:0] {
    IDLE,
    SIN,
    COS,
    MAC,
    DONE
  } foc_state_e;

endpackage

// File: rtl/foc_mul_q15.sv
// foc_mul_q15: combinational signed 32x16 multiply, floored arithmetic shift by 15.
module foc_mul_q15
  import foc_pkg::*;
(
  input  logic signed [31:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [32:0] p_o
);

  logic signed [47:0] full;

  assign full = 48'(a_i) * 48'(b_i);
  // >>> floors toward minus infinity; 33 bits hold the full range incl. (-2^31)*(-2^15)
  assign p_o  = 33'(full >>> Q15_SHIFT);

endmodule

// File: rtl/foc_inv_park.sv
// foc_inv_park: inverse Park transform using a shared sine table and a single Q15 multiplier.
// Build option: define INV_PARK_SAT_EN to saturate the 34-bit results instead of wrapping.
// state | meaning
// IDLE  | waiting for start_i, angle_o holds its last value
// SIN   | table addressed with angle, S captured on last cycle
// COS   | table addressed with angle + quarter turn, C captured on last cycle
// MAC   | products vd*C, vq*S, vd*S, vq*C, one per cycle
// DONE  | done_o pulse, results already on valpha_o/vbeta_o
module foc_inv_park
  import foc_pkg::*;
#(
  parameter int SIN_LAT = 2,
  parameter int ANG_W   = ANG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic signed [31:0]      vd_i,
  input  logic signed [31:0]      vq_i,
  input  logic        [ANG_W-1:0] angle_i,
  output logic        [ANG_W-1:0] angle_o,
  input  logic signed [15:0]      sin_i,
  output logic signed [31:0]      valpha_o,
  output logic signed [31:0]      vbeta_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [ANG_W-1:0] QTR    = ANG_W'(1) << (ANG_W - 2);
  localparam logic [2:0]       LAT_LD = 3'(SIN_LAT);

`ifdef INV_PARK_SAT_EN
  localparam logic signed [33:0] SAT_MAX = 34'sd2147483647;
  localparam logic signed [33:0] SAT_MIN = -34'sd2147483648;
`endif

  function automatic logic signed [31:0] reduce(input logic signed [33:0] x);
`ifdef INV_PARK_SAT_EN
    if (x > SAT_MAX) return 32'sh7FFF_FFFF;
    if (x < SAT_MIN) return 32'sh8000_0000;
`endif
    return $signed(x[31:0]);
  endfunction

  foc_state_e               state_q, state_d;
  logic        [2:0]        cnt_q, cnt_d;
  logic signed [31:0]       vd_q, vd_d, vq_q, vq_d;
  logic        [ANG_W-1:0]  ang_q, ang_d, angle_q, angle_d;
  logic signed [15:0]       s_q, s_d, c_q, c_d;
  logic signed [33:0]       acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [31:0]       valpha_q, valpha_d, vbeta_q, vbeta_d;

  logic signed [31:0]       mul_a;
  logic signed [15:0]       mul_b;
  logic signed [32:0]       prod;
  logic signed [33:0]       prod_ext, sum_a, sum_b;

  // cnt 3..0 selects vd*C, vq*S, vd*S, vq*C
  assign mul_a    = cnt_q[0] ? vd_q : vq_q;
  assign mul_b    = (cnt_q[1] ^ cnt_q[0]) ? s_q : c_q;
  assign prod_ext = {prod[32], prod};
  assign sum_a    = acc_a_q - prod_ext;
  assign sum_b    = acc_b_q + prod_ext;

  foc_mul_q15 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vd_d     = vd_q;
    vq_d     = vq_q;
    ang_d    = ang_q;
    angle_d  = angle_q;
    s_d      = s_q;
    c_d      = c_q;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    valpha_d = valpha_q;
    vbeta_d  = vbeta_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          vd_d    = vd_i;
          vq_d    = vq_i;
          ang_d   = angle_i;
          angle_d = angle_i;
          cnt_d   = LAT_LD;
          state_d = SIN;
        end
      end
      SIN: begin
        if (cnt_q == 3'd0) begin
          s_d     = sin_i;
          angle_d = ang_q + QTR;
          cnt_d   = LAT_LD;
          state_d = COS;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      COS: begin
        if (cnt_q == 3'd0) begin
          c_d     = sin_i;
          cnt_d   = 3'd3;
          state_d = MAC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      MAC: begin
        cnt_d = cnt_q - 3'd1;
        case (cnt_q[1:0])
          2'd3:    acc_a_d = prod_ext;
          2'd2:    acc_a_d = sum_a;
          2'd1:    acc_b_d = prod_ext;
          default: begin
            acc_b_d  = sum_b;
            valpha_d = reduce(acc_a_q);
            vbeta_d  = reduce(sum_b);
            cnt_d    = 3'd0;
            state_d  = DONE;
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vd_q     <= '0;
      vq_q     <= '0;
      ang_q    <= '0;
      angle_q  <= '0;
      s_q      <= '0;
      c_q      <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      valpha_q <= '0;
      vbeta_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vd_q     <= vd_d;
      vq_q     <= vq_d;
      ang_q    <= ang_d;
      angle_q  <= angle_d;
      s_q      <= s_d;
      c_q      <= c_d;
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      valpha_q <= valpha_d;
      vbeta_q  <= vbeta_d;
    end
  end

  assign angle_o  = angle_q;
  assign valpha_o = valpha_q;
  assign vbeta_o  = vbeta_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);

endmodule

// File: tb/tb_foc_inv_park.sv
// tb_foc_inv_park: three instances (SIN_LAT 2, 1, 7) fed by a sine-table model; results scoreboarded.
module tb_foc_inv_park;

  localparam int LAT [3] = '{2, 1, 7};
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct {
    int          g;
    logic [31:0] ea;
    logic [31:0] eb;
    int          cyc;
  } exp_t;

  logic               clk;
  logic               rst;
  logic        [2:0]  start;
  logic signed [31:0] vd, vq;
  logic        [11:0] ang;
  logic        [11:0] ang_o  [3];
  logic signed [15:0] sin_v  [3];
  logic        [31:0] valpha [3];
  logic        [31:0] vbeta  [3];
  logic        [2:0]  busy, done;

  logic signed [15:0] sin_tab [4096];
  bit                 sin_force = 1'b0;
  exp_t               sb[$];
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = LAT[g];
    logic [11:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= ang_o[g];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign sin_v[g] = sin_force ? -16'sd32768 : sin_tab[pipe[L-1]];

    foc_inv_park #(.SIN_LAT(L), .ANG_W(12)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start[g]),
      .vd_i     (vd),
      .vq_i     (vq),
      .angle_i  (ang),
      .angle_o  (ang_o[g]),
      .sin_i    (sin_v[g]),
      .valpha_o (valpha[g]),
      .vbeta_o  (vbeta[g]),
      .busy_o   (busy[g]),
      .done_o   (done[g])
    );
  end

  function automatic longint pq(input longint a, input longint b);
    return (a * b) >>> 15;
  endfunction

  function automatic logic [31:0] red(input longint x);
`ifdef INV_PARK_SAT_EN
    if (x > MAXV) return 32'h7FFF_FFFF;
    if (x < MINV) return 32'h8000_0000;
`endif
    return x[31:0];
  endfunction

  function automatic void model(input logic signed [31:0] m_vd, input logic signed [31:0] m_vq,
                                input logic [11:0] m_ang, output logic [31:0] ea, output logic [31:0] eb);
    longint s, c, d, q;
    s = sin_force ? -64'sd32768 : longint'(sin_tab[m_ang]);
    c = sin_force ? -64'sd32768 : longint'(sin_tab[12'(m_ang + 12'd1024)]);
    d = longint'(m_vd);
    q = longint'(m_vq);
    ea = red(pq(d, c) - pq(q, s));
    eb = red(pq(d, s) + pq(q, c));
  endfunction

  // Scoreboard: every done pulse must match the oldest pending entry of its instance
  always @(negedge clk) begin
    int k;
    for (int g = 0; g < 3; g++) begin
      if (done[g] === 1'b1) begin
        k = -1;
        for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].g == g) k = i;
        checks++;
        if (k < 0) begin
          errors++;
          $display("FAIL unexpected_done inst %0d at cycle %0d", g, cyc);
        end else begin
          checks += 2;
          if (valpha[g] !== sb[k].ea) begin
            errors++;
            $display("FAIL valpha inst %0d got %h expected %h", g, valpha[g], sb[k].ea);
          end
          if (vbeta[g] !== sb[k].eb) begin
            errors++;
            $display("FAIL vbeta inst %0d got %h expected %h", g, vbeta[g], sb[k].eb);
          end
          if (cyc != sb[k].cyc) begin
            errors++;
            $display("FAIL done_cycle inst %0d got %0d expected %0d", g, cyc, sb[k].cyc);
          end
          sb.delete(k);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] mask, input logic [31:0] a_vd, input logic [31:0] a_vq,
                       input logic [11:0] a_ang, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    vd  = a_vd;
    vq  = a_vq;
    ang = a_ang;
    for (int g = 0; g < 3; g++) begin
      if (mask[g]) begin
        start[g] = 1'b1;
        e.g = g; e.ea = ea; e.eb = eb; e.cyc = cyc + 2 * LAT[g] + 7;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    start = '0;
  endtask

  task automatic drain(output bit ok);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (sb.size() == 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = '0;
    vd = '0; vq = '0; ang = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({busy[g], done[g], valpha[g], vbeta[g], ang_o[g]} !== 78'd0) begin
        errors++;
        $display("FAIL reset_state inst %0d busy %b done %b va %h vb %h ang %h expected all 0",
                 g, busy[g], done[g], valpha[g], vbeta[g], ang_o[g]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    logic [11:0] ea;
    issue(3'b001, 32'd0, 32'd1000, 12'd0, 32'd0, 32'd999);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b expected 1", busy[0]); end
    for (int i = 1; i <= 2 * (LAT[0] + 1); i++) begin
      ea = (i <= LAT[0] + 1) ? 12'd0 : 12'd1024;
      checks++;
      if (ang_o[0] !== ea) begin
        errors++;
        $display("FAIL angle_seq step %0d got %0d expected %0d", i, ang_o[0], ea);
      end
      @(negedge clk);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout pending %0d expected 0", sb.size()); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || ang_o[0] !== 12'd1024 || valpha[0] !== 32'd0 || vbeta[0] !== 32'd999) begin
        errors++;
        $display("FAIL idle_hold busy %b ang %0d va %h vb %h expected 0 1024 0 999",
                 busy[0], ang_o[0], valpha[0], vbeta[0]);
      end
    end
  endtask

  task automatic test_angle_wrap;
    bit ok;
    logic [31:0] ea, eb;
    logic [11:0] exp_ang;
    issue(3'b001, 32'd0, 32'd1000, 12'd1024, 32'hFFFF_FC19, 32'd0);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL quarter_timeout pending %0d expected 0", sb.size()); end
    model(32'sd123456, -32'sd654321, 12'd3500, ea, eb);
    issue(3'b001, 32'sd123456, -32'sd654321, 12'd3500, ea, eb);
    for (int i = 1; i <= 6; i++) begin
      exp_ang = (i <= 3) ? 12'd3500 : 12'd428;
      checks++;
      if (ang_o[0] !== exp_ang) begin
        errors++;
        $display("FAIL angle_wrap step %0d got %0d expected %0d", i, ang_o[0], exp_ang);
      end
      @(negedge clk);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout pending %0d expected 0", sb.size()); end
  endtask

  task automatic test_patterns;
    bit ok;
    logic [31:0] ea, eb, pvd, pvq;
    logic [11:0] angs [6] = '{12'd0, 12'd1023, 12'd2048, 12'd3072, 12'd4095, 12'd777};
    for (int i = 0; i < 6; i++) begin
      pvd = $urandom;
      pvq = $urandom;
      model(pvd, pvq, angs[i], ea, eb);
      issue(3'b111, pvd, pvq, angs[i], ea, eb);
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pattern_timeout %0d pending %0d expected 0", i, sb.size()); end
    end
  endtask

  task automatic test_extremes;
    bit ok;
    logic [31:0] ea, eb;
`ifdef INV_PARK_SAT_EN
    issue(3'b111, 32'h7FFF_FFFF, 32'h8000_0001, 12'd512, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
`else
    issue(3'b111, 32'h7FFF_FFFF, 32'h8000_0001, 12'd512, 32'hB503_FFFF, 32'hFFFF_FFFF);
`endif
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL extreme_pos_timeout pending %0d expected 0", sb.size()); end
    model(32'h8000_0001, 32'h7FFF_FFFF, 12'd512, ea, eb);
    issue(3'b111, 32'h8000_0001, 32'h7FFF_FFFF, 12'd512, ea, eb);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL extreme_neg_timeout pending %0d expected 0", sb.size()); end
    sin_force = 1'b1;
`ifdef INV_PARK_SAT_EN
    issue(3'b111, 32'h8000_0000, 32'h8000_0000, 12'd100, 32'd0, 32'h7FFF_FFFF);
`else
    issue(3'b111, 32'h8000_0000, 32'h8000_0000, 12'd100, 32'd0, 32'd0);
`endif
    drain(ok);
    sin_force = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL min_value_timeout pending %0d expected 0", sb.size()); end
  endtask

  task automatic test_ignore_start;
    bit ok;
    logic [31:0] ea, eb;
    model(32'sd5000000, 32'sd7000000, 12'd300, ea, eb);
    issue(3'b001, 32'sd5000000, 32'sd7000000, 12'd300, ea, eb);
    for (int i = 1; i <= 2 * LAT[0] + 6; i++) begin
      start[0] = 1'b1;
      vd = $urandom;
      vq = $urandom;
      ang = 12'($urandom);
      @(negedge clk);
    end
    start[0] = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_timeout pending %0d expected 0", sb.size()); end
    repeat (2 * LAT[0] + 12) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL ignore_queued busy got %b expected 0", busy[0]); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] ea, eb;
    model(32'sd99999, 32'sd11111, 12'd900, ea, eb);
    issue(3'b001, 32'sd99999, 32'sd11111, 12'd900, ea, eb);
    repeat (2 * LAT[0] + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    checks++;
    if ({busy[0], done[0], valpha[0], vbeta[0], ang_o[0]} !== 78'd0) begin
      errors++;
      $display("FAIL abort_state busy %b done %b va %h vb %h ang %h expected all 0",
               busy[0], done[0], valpha[0], vbeta[0], ang_o[0]);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy[0]); end
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_priority busy got %b expected 0", busy[0]); end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_priority_late busy got %b expected 0", busy[0]); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    exp_t e;
    logic [31:0] ea, eb;
    for (int g = 0; g < 3; g++) begin
      model(32'sd2000000, -32'sd3000000, 12'd1500, ea, eb);
      issue(3'(1 << g), 32'sd2000000, -32'sd3000000, 12'd1500, ea, eb);
      n = 0;
      while (done[g] !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (done[g] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_first_done inst %0d got %b expected 1", g, done[g]);
      end
      // start is already high in the DONE cycle; only the following IDLE cycle may accept it
      vd = -32'sd4000000;
      vq = 32'sd8000000;
      ang = 12'd2900;
      model(vd, vq, ang, ea, eb);
      start[g] = 1'b1;
      e.g = g; e.ea = ea; e.eb = eb; e.cyc = cyc + 1 + 2 * LAT[g] + 7;
      sb.push_back(e);
      @(negedge clk);
      @(negedge clk);
      start[g] = 1'b0;
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout inst %0d pending %0d expected 0", g, sb.size()); end
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    real x;
    for (int i = 0; i < 4096; i++) begin
      x = 32767.0 * $sin(2.0 * 3.141592653589793 * i / 4096.0);
      sin_tab[i] = 16'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
    end
    test_reset();
    test_basic();
    test_angle_wrap();
    test_patterns();
    test_extremes();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
